// File: rtl/rv_wb_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rv_wb_arb_if
// Brief    : Bundle of writeback, load-return, decode-check and register-file
//            signals shared by rv_wb_arb and its driver.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface rv_wb_arb_if #(
  parameter int NREGS = 16
) ();
  logic             alu_we;
  logic [4:0]       alu_awd;
  logic [31:0]      alu_wd;
  logic             ld_issue;
  logic [4:0]       ld_iawd;
  logic             ld_rvalid;
  logic [4:0]       ld_rawd;
  logic [31:0]      ld_rdata;
  logic             ld_ready;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic [4:0]       chk_rd;
  logic             stall;
  logic [NREGS-1:0] busy;
  logic [4:0]       awd;
  logic             we;
  logic [31:0]      wd;

  modport master (
    output alu_we, alu_awd, alu_wd,
    output ld_issue, ld_iawd,
    output ld_rvalid, ld_rawd, ld_rdata,
    output chk_rs1, chk_rs2, chk_rd,
    input  ld_ready, stall, busy, awd, we, wd
  );

  modport slave (
    input  alu_we, alu_awd, alu_wd,
    input  ld_issue, ld_iawd,
    input  ld_rvalid, ld_rawd, ld_rdata,
    input  chk_rs1, chk_rs2, chk_rd,
    output ld_ready, stall, busy, awd, we, wd
  );
endinterface
`default_nettype wire

// File: rtl/rv_wb_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rv_wb_arb
// Brief    : Register-file write-port arbiter (ALU over buffered/incoming loads)
//            with a load-return FIFO and per-register busy scoreboard.
// Revision : 1.0
// ----------------------------------------------------------------------------
module rv_wb_arb #(
  parameter int NREGS = 16,
  parameter int DEPTH = 2
) (
  input logic        clk,
  input logic        reset,
  rv_wb_arb_if.slave bus
);
  localparam int              c_cw   = $clog2(DEPTH + 1);
  localparam int              c_pw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  logic [c_cw-1:0]  count_q, count_d;
  logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]       fifo_awd_q [DEPTH];
  logic [31:0]      fifo_wd_q  [DEPTH];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             we_q, we_d;
  logic [4:0]       awd_q, awd_d;
  logic [31:0]      wd_q, wd_d;

  logic        empty, full, accept, push, pop, sel_load, sel_any;
  logic [4:0]  sel_awd;
  logic [31:0] sel_wd;
  logic [31:0] busy_ext;

  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    if (int'(p) >= DEPTH - 1) return '0;
    return p + c_pw'(1);
  endfunction

  assign empty        = (count_q == '0);
  assign full         = (count_q == c_full);
  assign bus.ld_ready = ~full & ~reset;
  assign accept       = bus.ld_rvalid & bus.ld_ready;

  // ALU always wins; a load reaches the port from the FIFO head first, so
  // an incoming load only bypasses the FIFO when it is empty.
  assign pop      = ~bus.alu_we & ~empty;
  assign push     = accept & (bus.alu_we | ~empty);
  assign sel_load = ~bus.alu_we & (~empty | accept);
  assign sel_any  = bus.alu_we | sel_load;

  always_comb begin
    sel_awd = bus.ld_rawd;
    sel_wd  = bus.ld_rdata;
    if (bus.alu_we) begin
      sel_awd = bus.alu_awd;
      sel_wd  = bus.alu_wd;
    end else if (!empty) begin
      sel_awd = fifo_awd_q[rd_ptr_q];
      sel_wd  = fifo_wd_q[rd_ptr_q];
    end

    we_d     = sel_any & addr_ok(sel_awd);
    awd_d    = sel_any ? sel_awd : awd_q;
    wd_d     = sel_any ? sel_wd  : wd_q;
    count_d  = count_q + c_cw'(push) - c_cw'(pop);
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    // Set is applied after clear so a same-cycle set of the same register wins.
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (sel_load && (sel_awd == 5'(r))) busy_d[r] = 1'b0;
      if (bus.ld_issue && (bus.ld_iawd == 5'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      awd_q    <= '0;
      wd_q     <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      awd_q    <= awd_d;
      wd_q     <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_awd_q[wr_ptr_q] <= bus.ld_rawd;
      fifo_wd_q[wr_ptr_q]  <= bus.ld_rdata;
    end
  end

  // Out-of-range check indices land on the zero-extended upper bits.
  assign busy_ext  = 32'(busy_q);
  assign bus.stall = busy_ext[bus.chk_rs1] | busy_ext[bus.chk_rs2] | busy_ext[bus.chk_rd];
  assign bus.busy  = busy_q;
  assign bus.we    = we_q;
  assign bus.awd   = awd_q;
  assign bus.wd    = wd_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_wb_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_rv_wb_arb
// Brief    : Scoreboard bench for rv_wb_arb: queue-based reference model,
//            directed scenarios followed by contract-respecting random traffic.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_rv_wb_arb;
  localparam int NREGS = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_wb_arb_if #(.NREGS(NREGS)) bus ();
  rv_wb_arb #(.NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          due;
  } wr_t;

  wr_t              expq[$];
  wr_t              bufq[$];
  wr_t              me;
  logic [NREGS-1:0] m_busy = '0;
  logic [NREGS-1:0] m_busy_nxt;
  bit               outst[32];
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;
  bit               run = 1'b0;
  bit               last_acc = 1'b0;
  bit               last_rst = 1'b0;

  function automatic bit ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  function automatic bit bz(input logic [4:0] a);
    if (!ok(a)) return 1'b0;
    return m_busy[int'(a)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    bus.alu_we = 1'b0; bus.alu_awd = '0; bus.alu_wd = '0;
    bus.ld_issue = 1'b0; bus.ld_iawd = '0;
    bus.ld_rvalid = 1'b0; bus.ld_rawd = '0; bus.ld_rdata = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
  endtask

  // One cycle: check combinational outputs, advance the reference model,
  // queue the expected port write for the next edge, then clock.
  task automatic tick();
    bit  rdy, acc, clr;
    wr_t e;
    #1;
    rdy = !reset && (bufq.size() < DEPTH);
    chk("ld_ready", 32'(bus.ld_ready), 32'(rdy));
    if (!reset) begin
      chk("stall", 32'(bus.stall), 32'(bz(bus.chk_rs1) | bz(bus.chk_rs2) | bz(bus.chk_rd)));
      assert (!(bus.ld_issue && bz(bus.ld_iawd))) else $error("contract: issue to busy reg");
      assert (!(bus.alu_we && bz(bus.alu_awd))) else $error("contract: alu to busy reg");
      assert (!bus.ld_rvalid || outst[int'(bus.ld_rawd)]) else $error("contract: return not outstanding");
    end
    acc = bus.ld_rvalid && rdy;
    clr = 1'b0;
    e = '{5'd0, 32'd0, 0};
    m_busy_nxt = m_busy;
    if (reset) begin
      bufq.delete();
      m_busy_nxt = '0;
      foreach (outst[i]) outst[i] = 1'b0;
    end else begin
      if (bus.alu_we) begin
        if (ok(bus.alu_awd)) expq.push_back('{bus.alu_awd, bus.alu_wd, cyc + 1});
        if (acc) bufq.push_back('{bus.ld_rawd, bus.ld_rdata, 0});
      end else if (bufq.size() > 0) begin
        e = bufq.pop_front();
        clr = 1'b1;
        if (acc) bufq.push_back('{bus.ld_rawd, bus.ld_rdata, 0});
      end else if (acc) begin
        e = '{bus.ld_rawd, bus.ld_rdata, 0};
        clr = 1'b1;
      end
      if (clr && ok(e.a)) begin
        expq.push_back('{e.a, e.d, cyc + 1});
        m_busy_nxt[int'(e.a)] = 1'b0;
      end
      if (bus.ld_issue && ok(bus.ld_iawd)) begin
        m_busy_nxt[int'(bus.ld_iawd)] = 1'b1;
        outst[int'(bus.ld_iawd)] = 1'b1;
      end
      if (acc) outst[int'(bus.ld_rawd)] = 1'b0;
    end
    last_acc = acc;
    last_rst = reset;
    @(posedge clk);
    cyc++;
    #1;
    m_busy = m_busy_nxt;
    run = 1'b1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      bit exp_we;
      exp_we = (expq.size() > 0) && (expq[0].due == cyc);
      chk("we", 32'(bus.we), 32'(exp_we));
      if (exp_we) begin
        me = expq.pop_front();
        if (bus.we === 1'b1) begin
          chk("awd", 32'(bus.awd), 32'(me.a));
          chk("wd", bus.wd, me.d);
        end
      end
      chk("busy", 32'(bus.busy), 32'(m_busy));
    end
  end

  task automatic issue(input logic [4:0] r);
    idle();
    bus.ld_issue = 1'b1;
    bus.ld_iawd  = r;
    tick();
  endtask

  initial begin
    logic [4:0] rets[$];
    logic [4:0] cand[$];
    logic [4:0] r;

    // Reset then idle
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();

    // ALU only, including write to x0
    bus.alu_we = 1'b1; bus.alu_awd = 5'd3; bus.alu_wd = 32'h12345678;
    tick();
    bus.alu_awd = 5'd0;
    tick();
    idle(); tick();

    // Load scoreboard
    issue(5'd5);
    idle(); bus.chk_rs1 = 5'd5; tick();
    bus.ld_rvalid = 1'b1; bus.ld_rawd = 5'd5; bus.ld_rdata = 32'hDEADBEEF;
    tick();
    idle(); bus.chk_rs1 = 5'd5; tick(); tick();

    // Collision ALU vs load
    issue(5'd7);
    idle();
    bus.alu_we = 1'b1; bus.alu_awd = 5'd2; bus.alu_wd = 32'h1;
    bus.ld_rvalid = 1'b1; bus.ld_rawd = 5'd7; bus.ld_rdata = 32'h2;
    bus.chk_rd = 5'd7;
    tick();
    idle(); bus.chk_rd = 5'd7; tick(); tick();

    // Backpressure: ALU burst while three loads return
    issue(5'd4); issue(5'd6); issue(5'd8);
    idle();
    rets = '{5'd4, 5'd6, 5'd8};
    for (int i = 0; i < 14 && (rets.size() > 0 || i < 4); i++) begin
      bus.alu_we  = (i < 4);
      bus.alu_awd = 5'(10 + i);
      bus.alu_wd  = 32'(100 + i);
      bus.ld_rvalid = (rets.size() > 0);
      if (rets.size() > 0) begin
        bus.ld_rawd  = rets[0];
        bus.ld_rdata = 32'hA5A50000 | 32'(rets[0]);
      end
      tick();
      if (last_acc) void'(rets.pop_front());
    end
    idle(); repeat (4) tick();

    // Reset with two buffered loads and x4 busy
    issue(5'd4); issue(5'd9); issue(5'd11);
    idle();
    bus.alu_we = 1'b1; bus.alu_awd = 5'd1; bus.alu_wd = 32'hCAFE0001;
    bus.ld_rvalid = 1'b1; bus.ld_rawd = 5'd9; bus.ld_rdata = 32'h99;
    tick();
    bus.ld_rawd = 5'd11; bus.ld_rdata = 32'h11;
    tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0; repeat (4) tick();

    // Random traffic obeying the input contract
    for (int n = 0; n < 800; n++) begin
      bit hold;
      hold = bus.ld_rvalid && !last_acc && !last_rst;
      reset = ($urandom_range(0, 99) == 0);
      bus.alu_we  = ($urandom_range(0, 9) < 4);
      r = 5'($urandom_range(0, 31));
      bus.alu_awd = bz(r) ? 5'd0 : r;
      bus.alu_wd  = $urandom;
      bus.ld_issue = 1'b0;
      bus.ld_iawd  = '0;
      if ($urandom_range(0, 9) < 3) begin
        r = 5'($urandom_range(1, NREGS - 1));
        if (!bz(r)) begin
          bus.ld_issue = 1'b1;
          bus.ld_iawd  = r;
        end
      end
      if (!hold) begin
        cand.delete();
        foreach (outst[i]) if (outst[i]) cand.push_back(5'(i));
        bus.ld_rvalid = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
        if (bus.ld_rvalid) begin
          bus.ld_rawd  = cand[$urandom_range(0, cand.size() - 1)];
          bus.ld_rdata = $urandom;
        end
      end
      bus.chk_rs1 = 5'($urandom_range(0, 31));
      bus.chk_rs2 = 5'($urandom_range(0, 31));
      bus.chk_rd  = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (8) tick();
    chk("drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
